// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: datapath widths and instruction-cache configuration.
package mips_pkg;

    localparam int PC_WIDTH     = 32;
    localparam int INSTR_WITDTH = 32;

    localparam int ICACHE_LINES = 16;
    localparam int ICACHE_WPL   = 4;

    typedef enum logic {IC_IDLE, IC_REFILL} icache_state_e;

endpackage

// File: rtl/mips_icache_if.sv
// Read-only backing-memory bus: the cache is master, the memory is slave.
interface mips_icache_if;
    import mips_pkg::*;

    logic                    req;
    logic [PC_WIDTH-1:0]     addr;
    logic                    ack;
    logic [INSTR_WITDTH-1:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/mips_icache_refill_fsm.sv
// Line-refill sequencer: captures the missing line, walks its words over req/ack and
// produces the array write strobes and the end-of-refill valid decision.
//  state     | meaning
//  IC_IDLE   | lookups active; a miss latches tag/index and starts a refill
//  IC_REFILL | fetching words 0..WPL-1 of the captured line, no lookup hits
module mips_icache_refill_fsm
    import mips_pkg::*;
#(
    parameter int LINES          = ICACHE_LINES,
    parameter int WORDS_PER_LINE = ICACHE_WPL,
    localparam int OFF   = $clog2(WORDS_PER_LINE),
    localparam int IDX   = $clog2(LINES),
    localparam int TAG_W = PC_WIDTH - IDX - OFF - 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             miss_i,
    input  logic             flush_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic [IDX-1:0]   index_i,
    mips_icache_if.master    mem_bus,
    output logic             idle_o,
    output logic             enter_o,
    output logic             wr_en_o,
    output logic             done_o,
    output logic             fill_valid_o,
    output logic [TAG_W-1:0] wr_tag_o,
    output logic [IDX-1:0]   wr_index_o,
    output logic [OFF-1:0]   wr_word_o
);

    icache_state_e    state_q, state_d;
    logic [OFF-1:0]   cnt_q, cnt_d;
    logic [TAG_W-1:0] miss_tag_q, miss_tag_d;
    logic [IDX-1:0]   miss_idx_q, miss_idx_d;
    logic             flush_pend_q, flush_pend_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IC_IDLE;
            cnt_q        <= '0;
            miss_tag_q   <= '0;
            miss_idx_q   <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            miss_tag_q   <= miss_tag_d;
            miss_idx_q   <= miss_idx_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        miss_tag_d   = miss_tag_q;
        miss_idx_d   = miss_idx_q;
        flush_pend_d = flush_pend_q;
        enter_o      = 1'b0;
        wr_en_o      = 1'b0;
        done_o       = 1'b0;
        unique case (state_q)
            IC_IDLE: begin
                if (miss_i) begin
                    state_d    = IC_REFILL;
                    miss_tag_d = tag_i;
                    miss_idx_d = index_i;
                    cnt_d      = '0;
                    enter_o    = 1'b1;
                end
            end
            IC_REFILL: begin
                // A flush never aborts the handshake; it is applied when the line completes.
                if (flush_i) flush_pend_d = 1'b1;
                if (mem_bus.ack) begin
                    wr_en_o = 1'b1;
                    cnt_d   = cnt_q + OFF'(1);
                    if (cnt_q == OFF'(WORDS_PER_LINE - 1)) begin
                        done_o       = 1'b1;
                        state_d      = IC_IDLE;
                        flush_pend_d = 1'b0;
                    end
                end
            end
            default: state_d = IC_IDLE;
        endcase
    end

    assign idle_o       = (state_q == IC_IDLE);
    assign fill_valid_o = ~(flush_pend_q | flush_i);
    assign wr_tag_o     = miss_tag_q;
    assign wr_index_o   = miss_idx_q;
    assign wr_word_o    = cnt_q;
    assign mem_bus.req  = (state_q == IC_REFILL);
    assign mem_bus.addr = {miss_tag_q, miss_idx_q, cnt_q, 2'b00};

endmodule

// File: rtl/mips_icache.sv
// Direct-mapped read-only instruction cache: combinational hit path, tag/data/valid
// storage and saturating hit/miss counters around the refill sequencer.
module mips_icache
    import mips_pkg::*;
#(
    parameter int LINES          = ICACHE_LINES,
    parameter int WORDS_PER_LINE = ICACHE_WPL
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [PC_WIDTH-1:0]     pc_i,
    output logic [INSTR_WITDTH-1:0] instr_o,
    output logic                    stall_o,
    input  logic                    flush_i,
    mips_icache_if.master           mem_bus,
    output logic [31:0]             hit_count_o,
    output logic [31:0]             miss_count_o
);

    localparam int OFF   = $clog2(WORDS_PER_LINE);
    localparam int IDX   = $clog2(LINES);
    localparam int TAG_W = PC_WIDTH - IDX - OFF - 2;

    logic [OFF-1:0]   word;
    logic [IDX-1:0]   index;
    logic [TAG_W-1:0] tag;
    logic             pc_unused;

    assign word      = pc_i[OFF+1:2];
    assign index     = pc_i[IDX+OFF+1:OFF+2];
    assign tag       = pc_i[PC_WIDTH-1:IDX+OFF+2];
    assign pc_unused = ^pc_i[1:0];

    logic [LINES-1:0]        valid_q, valid_d;
    logic [TAG_W-1:0]        tag_q  [LINES];
    logic [INSTR_WITDTH-1:0] data_q [LINES][WORDS_PER_LINE];
    logic [31:0]             hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    logic             idle, enter, wr_en, done, fill_valid, hit, flush_all;
    logic [TAG_W-1:0] wr_tag;
    logic [IDX-1:0]   wr_index;
    logic [OFF-1:0]   wr_word;

    mips_icache_refill_fsm #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_refill_fsm (
        .clk          (clk),
        .rst_n        (rst_n),
        .miss_i       (~hit),
        .flush_i      (flush_i),
        .tag_i        (tag),
        .index_i      (index),
        .mem_bus      (mem_bus),
        .idle_o       (idle),
        .enter_o      (enter),
        .wr_en_o      (wr_en),
        .done_o       (done),
        .fill_valid_o (fill_valid),
        .wr_tag_o     (wr_tag),
        .wr_index_o   (wr_index),
        .wr_word_o    (wr_word)
    );

    assign hit     = idle & valid_q[index] & (tag_q[index] == tag);
    assign stall_o = ~hit;
    assign instr_o = hit ? data_q[index][word] : '0;

    // A flush seen during refill also kills the line that just completed.
    assign flush_all = (idle & flush_i) | (done & ~fill_valid);

    always_comb begin
        valid_d = valid_q;
        if (flush_all) begin
            valid_d = '0;
        end else begin
            if (enter) valid_d[index]    = 1'b0;
            if (done)  valid_d[wr_index] = 1'b1;
        end
    end

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (hit && hit_cnt_q != '1)    hit_cnt_d  = hit_cnt_q + 32'd1;
        if (enter && miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            valid_q    <= valid_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[wr_index][wr_word] <= mem_bus.rdata;
            tag_q[wr_index]           <= wr_tag;
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;

endmodule

// File: tb/tb_mips_icache.sv
// Self-checking bench for mips_icache against a line-level cache model and a memory image.
module tb_mips_icache;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc = '0;
    logic        flush = 1'b0;
    logic [31:0] instr, hit_count, miss_count;
    logic        stall;

    mips_icache_if mem_bus();

    mips_icache #(.LINES(16), .WORDS_PER_LINE(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_i         (pc),
        .instr_o      (instr),
        .stall_o      (stall),
        .flush_i      (flush),
        .mem_bus      (mem_bus),
        .hit_count_o  (hit_count),
        .miss_count_o (miss_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem_img [bit [31:0]];
    bit          model_v    [16];
    logic [31:0] model_base [16];
    int unsigned model_hits, model_misses;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        logic [31:0] w;
        w = a & ~32'h3;
        if (mem_img.exists(w)) return mem_img[w];
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        int idx;
        idx = int'((a >> 4) & 32'hF);
        return model_v[idx] && (model_base[idx] == (a & ~32'hF));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model_v[i] = 1'b0;
        model_hits   = 0;
        model_misses = 0;
    endtask

    // Serves one 4-word refill starting at a negedge; returns at the negedge after the last ack.
    task automatic do_refill(input logic [31:0] base, input int maxd, input bit flush_w2);
        for (int k = 0; k < 4; k++) begin
            int d;
            logic [31:0] exp_addr;
            d = int'($urandom_range(maxd, 0));
            exp_addr = base + 32'(4 * k);
            for (int j = 0; j <= d; j++) begin
                checks++;
                if (mem_bus.req !== 1'b1 || mem_bus.addr !== exp_addr) begin
                    failures++;
                    $display("FAIL refill_addr word%0d: got req=%b addr=%h, expected req=1 addr=%h",
                             k, mem_bus.req, mem_bus.addr, exp_addr);
                end
                if (j == d) begin
                    mem_bus.ack   = 1'b1;
                    mem_bus.rdata = mem_val(exp_addr);
                    if (flush_w2 && k == 2) flush = 1'b1;
                end
                @(negedge clk);
                mem_bus.ack   = 1'b0;
                mem_bus.rdata = $urandom;
                flush         = 1'b0;
            end
        end
        checks++;
        if (mem_bus.req !== 1'b0) begin
            failures++;
            $display("FAIL req_drop: got req=%b after last ack, expected 0", mem_bus.req);
        end
    endtask

    // Presents address a at a negedge, services any misses, then spends one hit cycle on it.
    task automatic access(input logic [31:0] a, input int maxd, input bit flush_w2);
        logic [31:0] base;
        int idx;
        bit first;
        base  = a & ~32'hF;
        idx   = int'((a >> 4) & 32'hF);
        first = 1'b1;
        pc    = a;
        while (!model_hit(a)) begin
            #1;
            checks++;
            if (stall !== 1'b1 || instr !== 32'h0) begin
                failures++;
                $display("FAIL miss_out pc=%h: got stall=%b instr=%h, expected stall=1 instr=0",
                         a, stall, instr);
            end
            model_misses++;
            model_v[idx] = 1'b0;
            @(negedge clk);
            do_refill(base, maxd, flush_w2 && first);
            if (flush_w2 && first) begin
                for (int i = 0; i < 16; i++) model_v[i] = 1'b0;
            end else begin
                model_v[idx]    = 1'b1;
                model_base[idx] = base;
            end
            first = 1'b0;
        end
        #1;
        checks++;
        if (stall !== 1'b0 || instr !== mem_val(a)) begin
            failures++;
            $display("FAIL hit_out pc=%h: got stall=%b instr=%h, expected stall=0 instr=%h",
                     a, stall, instr, mem_val(a));
        end
        model_hits++;
        @(negedge clk);
    endtask

    task automatic check_counters(input string name);
        checks++;
        if (hit_count !== model_hits || miss_count !== model_misses) begin
            failures++;
            $display("FAIL counters_%s: got hit=%0d miss=%0d, expected hit=%0d miss=%0d",
                     name, hit_count, miss_count, model_hits, model_misses);
        end
    endtask

    task automatic test_reset();
        mem_bus.ack   = 1'b0;
        mem_bus.rdata = '0;
        rst_n = 1'b0;
        model_reset();
        pc = 32'h40;
        @(negedge clk);
        checks++;
        if (stall !== 1'b1 || instr !== 32'h0 || mem_bus.req !== 1'b0) begin
            failures++;
            $display("FAIL reset_out: got stall=%b instr=%h req=%b, expected 1 0 0",
                     stall, instr, mem_bus.req);
        end
        check_counters("reset");
        rst_n = 1'b1;
    endtask

    task automatic test_first_fill();
        mem_img[32'h40] = 32'h11;
        mem_img[32'h44] = 32'h22;
        mem_img[32'h48] = 32'h33;
        mem_img[32'h4C] = 32'h44;
        access(32'h40, 0, 1'b0);
        checks++;
        if (miss_count !== 32'd1) begin
            failures++;
            $display("FAIL first_fill_miss_count: got %0d, expected 1", miss_count);
        end
        check_counters("first_fill");
    endtask

    task automatic test_hit();
        logic [31:0] h0;
        h0 = hit_count;
        access(32'h48, 0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            mem_bus.ack = (i == 0);
            #1;
            checks++;
            if (stall !== 1'b0 || instr !== 32'h33) begin
                failures++;
                $display("FAIL hit_hold: got stall=%b instr=%h, expected stall=0 instr=00000033",
                         stall, instr);
            end
            model_hits++;
            @(negedge clk);
            mem_bus.ack = 1'b0;
        end
        checks++;
        if (hit_count !== h0 + 32'd3) begin
            failures++;
            $display("FAIL hit_count_step: got %0d, expected %0d", hit_count, h0 + 32'd3);
        end
        check_counters("hit");
    endtask

    task automatic test_conflict();
        logic [31:0] m0;
        m0 = miss_count;
        access(32'h140, 0, 1'b0);
        access(32'h40, 0, 1'b0);
        checks++;
        if (miss_count !== m0 + 32'd2) begin
            failures++;
            $display("FAIL conflict_misses: got %0d, expected %0d", miss_count, m0 + 32'd2);
        end
        check_counters("conflict");
    endtask

    task automatic test_flush_refill();
        logic [31:0] m0;
        m0 = miss_count;
        access(32'h284, 1, 1'b1);
        checks++;
        if (miss_count !== m0 + 32'd2) begin
            failures++;
            $display("FAIL flush_refill_remiss: got %0d, expected %0d", miss_count, m0 + 32'd2);
        end
        check_counters("flush_refill");
    endtask

    task automatic test_flush_idle();
        access(32'h40, 0, 1'b0);
        pc    = 32'h44;
        flush = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0 || instr !== mem_val(32'h44)) begin
            failures++;
            $display("FAIL flush_same_cycle: got stall=%b instr=%h, expected stall=0 instr=%h",
                     stall, instr, mem_val(32'h44));
        end
        model_hits++;
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < 16; i++) model_v[i] = 1'b0;
        access(32'h44, 0, 1'b0);
        check_counters("flush_idle");
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            access(32'($urandom_range(255, 0)) << 2, 3, 1'b0);
        end
        check_counters("random");
    endtask

    task automatic test_reset_mid_refill();
        pc = 32'h1300;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL midrst_miss: got stall=%b, expected 1", stall);
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            mem_bus.ack   = 1'b1;
            mem_bus.rdata = mem_val(32'h1300 + 32'(4 * k));
            @(negedge clk);
            mem_bus.ack = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_bus.req !== 1'b0 || stall !== 1'b1 || hit_count !== 0 || miss_count !== 0) begin
            failures++;
            $display("FAIL midrst_state: got req=%b stall=%b hit=%0d miss=%0d, expected 0 1 0 0",
                     mem_bus.req, stall, hit_count, miss_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        access(32'h1300, 1, 1'b0);
        check_counters("midrst");
    endtask

    initial begin
        test_reset();
        test_first_fill();
        test_hit();
        test_conflict();
        test_flush_refill();
        test_flush_idle();
        test_random();
        test_reset_mid_refill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
